round_controller: RTL and testbench
===================================

# round_controller

Upstream control stage of the Mastermind datapath. It synchronizes the four digit switches and the push button, and builds a 4-digit entry value. It latches that entry first as the secret code and then as successive guesses, and feeds both to the match-scoring logic. It reads back the exact-position count, tracks attempts, and drives the game `lock` output.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 65535: cycles the synchronized PB must be stable before its debounced level changes.
- `STEP_CYCLES`, default 65536: prescaler period for digit auto-increment while a switch is held.
- `MAX_ATTEMPTS`, default 10: guess limit per round; range 1..255.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `SW` in 4: raw digit switches; `SW[0]` edits digit w `[15:12]` … `SW[3]` edits digit z `[3:0]`.
- `PB` in 1: raw push button, active-high.
- `positions_matched_i` in 8: exact-match count from scoring, valid combinationally from `code_o`/`guess_o`.
- `entry_o` out 16: digits being edited, for the seven-segment display.
- `code_o` out 16: latched secret code.
- `guess_o` out 16: latched current guess.
- `guess_valid_o` out 1: one-cycle pulse when a new guess is latched.
- `attempts_o` out 8: guesses taken this round.
- `win_o` out 1: high in WIN.
- `lock` out 1: high in WIN or LOSE.

## Operation
- **Input synchronization:**
  - `SW` and `PB` each pass through a 2-flop synchronizer.
  - PB debounce: a counter resets on any change of the synchronized level. When it reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronized value.
  - `pb_press` is a one-cycle pulse on the debounced rising edge.
- **Digit editing:**
  - A free-running prescaler wraps at `STEP_CYCLES-1` and produces `tick`.
  - On `tick`, each digit whose synchronized SW bit is 1 increments by 1; 4'hF wraps to 4'h0.
  - Editing is enabled only in CODE and GUESS.
- **State machine:**
  - **CODE** (reset state): on `pb_press`, set `code_o` to `entry_o`, `entry_o` to 0 and `attempts_o` to 0, then go to GUESS.
  - **GUESS:** on `pb_press`, set `guess_o` to `entry_o`, pulse `guess_valid_o`, set `entry_o` to 0, increment `attempts_o` (saturating at 255), then go to SCORE.
  - **SCORE** (exactly one cycle): sample `positions_matched_i`.
    - If it equals 4, go to WIN.
    - Otherwise, if the limit is enabled and `attempts_o` == `MAX_ATTEMPTS`, go to LOSE.
    - Otherwise go to GUESS.
  - **WIN / LOSE:** `lock` = 1. On `pb_press`, clear `code_o`, `guess_o`, `entry_o` and `attempts_o`, then go to CODE.
- **Ignored presses:** `pb_press` in SCORE is ignored.

## Timing
- **Reset:** all outputs are 0, state is CODE, and the synchronizers, debounce counter and prescaler are 0. Reset mid-round aborts the round immediately.
- **PB latency:** from a raw PB edge to `pb_press` is 2 synchronizer cycles plus `DEBOUNCE_CYCLES`, plus 1 edge-detect cycle.
- **Latch timing:** `guess_o`, `guess_valid_o` and `attempts_o` update on the same edge that leaves GUESS. The SCORE decision happens on the next edge, so `lock`/`win_o` assert 2 cycles after `pb_press`.
- **Press and tick in the same cycle:** the latch captures the pre-increment entry, and the clear to 0 wins over the increment.
- **Bounce:** PB bounce shorter than `DEBOUNCE_CYCLES` yields no `pb_press`.

## Configuration
- `MASTERMIND_ATTEMPT_LIMIT_EN`
  - **Defined:** LOSE is reachable when `attempts_o` == `MAX_ATTEMPTS` without a win.
  - **Undefined:** LOSE is never entered, attempts are unlimited, `attempts_o` saturates at 255, and `MAX_ATTEMPTS` is unused.

## Structure
- **Package `mastermind_pkg`:**
  - state enum {CODE, GUESS, SCORE, WIN, LOSE}
  - `DIGIT_W`=4, `CODE_W`=16
  - `WIN_POSITIONS`=4
  - default `MAX_ATTEMPTS`
- **Sub-module `pb_debouncer`:** synchronizer, counter and rising-edge pulse. It is reusable for other buttons.
- Digit stepping and the FSM stay in `round_controller`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `STEP_CYCLES`=8 and `MAX_ATTEMPTS`=3, with the macro defined unless stated.
- **Code entry:** hold `SW[0]` for 3 ticks, then press PB → `code_o`=16'h3000, `entry_o`=0, state GUESS, `attempts_o`=0.
- **Debounce:** PB high for 3 cycles then low → no `pb_press` and no state change. PB held for 10 cycles → exactly one `pb_press`.
- **Correct guess:** code 16'h1234, guess 16'h1234, `positions_matched_i`=4 → `guess_valid_o` pulse, `attempts_o`=1, `win_o`=`lock`=1 two cycles after `pb_press`. A further press → CODE with all outputs 0.
- **Running out of attempts:** three wrong guesses with `positions_matched_i`=1 → `lock`=1, `win_o`=0, `attempts_o`=3. With the macro undefined, the same stimulus returns to GUESS and the 4th press gives `attempts_o`=4.
- **Digit wrap:** `SW[3]` held for 17 ticks → `entry_o` low digit = 4'h1. A press coincident with a tick latches the pre-tick value and `entry_o`=0 afterwards.
- **Reset mid-round:** assert `rst` in SCORE → outputs 0 asynchronously, state CODE, and no `guess_valid_o` after release.

Source files
------------

// File: rtl/mastermind_pkg.sv
// rtl/mastermind_pkg.sv - shared state encoding, widths and digit-stepping helper for the Mastermind round controller
package mastermind_pkg;

  localparam int DIGIT_W              = 4;
  localparam int CODE_W               = 16;
  localparam int NUM_DIGITS           = CODE_W / DIGIT_W;
  localparam int WIN_POSITIONS        = 4;
  localparam int MAX_ATTEMPTS_DEFAULT = 10;

  typedef enum logic [2:0] {
    CODE,
    GUESS,
    SCORE,
    WIN,
    LOSE
  } state_t;

  // Select bit 0 steps the most significant digit; each digit wraps F -> 0.
  function automatic logic [CODE_W-1:0] step_digits(input logic [CODE_W-1:0]     entry,
                                                    input logic [NUM_DIGITS-1:0] sel);
    logic [CODE_W-1:0] stepped;
    stepped = entry;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) begin
        stepped[CODE_W-1-i*DIGIT_W -: DIGIT_W] = entry[CODE_W-1-i*DIGIT_W -: DIGIT_W] + DIGIT_W'(1);
      end
    end
    return stepped;
  endfunction

endpackage

// File: rtl/pb_debouncer.sv
// rtl/pb_debouncer.sv - 2-flop synchronizer, stability counter and rising-edge press pulse for one button
module pb_debouncer #(
  parameter int DEBOUNCE_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          level_prev_q, level_prev_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d      = pb_i;
    sync2_d      = sync1_q;
    level_prev_d = level_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    // sync1 != sync2 means the synchronized level changes on this edge.
    if (sync1_q != sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_q == CNT_MAX) begin
      level_d = sync2_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      cnt_q        <= cnt_d;
    end
  end

  assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/round_controller.sv
// rtl/round_controller.sv - Mastermind entry/latch/attempt FSM; MASTERMIND_ATTEMPT_LIMIT_EN enables the LOSE state
module round_controller
  import mastermind_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter int STEP_CYCLES     = 65536,
  parameter int MAX_ATTEMPTS    = MAX_ATTEMPTS_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_DIGITS-1:0] SW,
  input  logic                  PB,
  input  logic [7:0]            positions_matched_i,
  output logic [CODE_W-1:0]     entry_o,
  output logic [CODE_W-1:0]     code_o,
  output logic [CODE_W-1:0]     guess_o,
  output logic                  guess_valid_o,
  output logic [7:0]            attempts_o,
  output logic                  win_o,
  output logic                  lock
);

  localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_CYCLES - 1);
`ifdef MASTERMIND_ATTEMPT_LIMIT_EN
  localparam logic [7:0] ATTEMPT_LIMIT = 8'(MAX_ATTEMPTS);
`endif

  logic                  pb_press;
  logic                  tick;
  logic [NUM_DIGITS-1:0] sw_sync1_q, sw_sync1_d;
  logic [NUM_DIGITS-1:0] sw_sync2_q, sw_sync2_d;
  logic [PW-1:0]         presc_q, presc_d;
  state_t                state_q, state_d;
  logic [CODE_W-1:0]     entry_q, entry_d;
  logic [CODE_W-1:0]     code_q, code_d;
  logic [CODE_W-1:0]     guess_q, guess_d;
  logic                  guess_valid_q, guess_valid_d;
  logic [7:0]            attempts_q, attempts_d;

  pb_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_pb_debouncer (
    .clk    (clk),
    .rst    (rst),
    .pb_i   (PB),
    .press_o(pb_press)
  );

  always_comb begin
    sw_sync1_d    = SW;
    sw_sync2_d    = sw_sync1_q;
    tick          = (presc_q == PRESC_MAX);
    presc_d       = tick ? '0 : presc_q + 1'b1;
    state_d       = state_q;
    entry_d       = entry_q;
    code_d        = code_q;
    guess_d       = guess_q;
    guess_valid_d = 1'b0;
    attempts_d    = attempts_q;

    if ((state_q == CODE || state_q == GUESS) && tick) begin
      entry_d = step_digits(entry_q, sw_sync2_q);
    end

    // Latches take entry_q (pre-tick) and the clear overrides any step above.
    case (state_q)
      CODE: begin
        if (pb_press) begin
          code_d     = entry_q;
          entry_d    = '0;
          attempts_d = '0;
          state_d    = GUESS;
        end
      end
      GUESS: begin
        if (pb_press) begin
          guess_d       = entry_q;
          guess_valid_d = 1'b1;
          entry_d       = '0;
          if (attempts_q != 8'hFF) begin
            attempts_d = attempts_q + 8'd1;
          end
          state_d = SCORE;
        end
      end
      SCORE: begin
        if (positions_matched_i == 8'(WIN_POSITIONS)) begin
          state_d = WIN;
        end
`ifdef MASTERMIND_ATTEMPT_LIMIT_EN
        else if (attempts_q == ATTEMPT_LIMIT) begin
          state_d = LOSE;
        end
`endif
        else begin
          state_d = GUESS;
        end
      end
      WIN, LOSE: begin
        if (pb_press) begin
          code_d     = '0;
          guess_d    = '0;
          entry_d    = '0;
          attempts_d = '0;
          state_d    = CODE;
        end
      end
      default: begin
        state_d = CODE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync1_q    <= '0;
      sw_sync2_q    <= '0;
      presc_q       <= '0;
      state_q       <= CODE;
      entry_q       <= '0;
      code_q        <= '0;
      guess_q       <= '0;
      guess_valid_q <= 1'b0;
      attempts_q    <= '0;
    end else begin
      sw_sync1_q    <= sw_sync1_d;
      sw_sync2_q    <= sw_sync2_d;
      presc_q       <= presc_d;
      state_q       <= state_d;
      entry_q       <= entry_d;
      code_q        <= code_d;
      guess_q       <= guess_d;
      guess_valid_q <= guess_valid_d;
      attempts_q    <= attempts_d;
    end
  end

  assign entry_o       = entry_q;
  assign code_o        = code_q;
  assign guess_o       = guess_q;
  assign guess_valid_o = guess_valid_q;
  assign attempts_o    = attempts_q;
  assign win_o         = (state_q == WIN);
  assign lock          = (state_q == WIN) || (state_q == LOSE);

endmodule

// File: tb/tb_round_controller.sv
// tb/tb_round_controller.sv - directed self-checking bench for round_controller (DEBOUNCE=4, STEP=8, MAX=3)
module tb_round_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sw;
  logic        pb;
  logic [7:0]  positions;
  logic [15:0] entry_o, code_o, guess_o;
  logic        guess_valid_o;
  logic [7:0]  attempts_o;
  logic        win_o, lock;

  int checks   = 0;
  int errors   = 0;
  int cyc;
  int gv_count = 0;
  int gv_snap;

  round_controller #(
    .DEBOUNCE_CYCLES(4),
    .STEP_CYCLES    (8),
    .MAX_ATTEMPTS   (3)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .SW                 (sw),
    .PB                 (pb),
    .positions_matched_i(positions),
    .entry_o            (entry_o),
    .code_o             (code_o),
    .guess_o            (guess_o),
    .guess_valid_o      (guess_valid_o),
    .attempts_o         (attempts_o),
    .win_o              (win_o),
    .lock               (lock)
  );

  always #5 clk = ~clk;

  // Edge counter since reset release: presc after edge k equals k mod 8.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (guess_valid_o) gv_count <= gv_count + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int k);
    int guard = 0;
    while (cyc < k && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < k) check("wait_bound", 64'(cyc), 64'(k));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    pb        = 1'b0;
    sw        = 4'b0000;
    positions = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {5'd0, entry_o, code_o, guess_o, attempts_o, guess_valid_o, win_o, lock};
  endfunction

  initial begin
    rst = 1'b1; pb = 1'b0; sw = 4'b0000; positions = 8'd0;
    @(negedge clk);
    check("reset_during", all_outs(), 64'd0);
    do_reset();
    check("reset_after", all_outs(), 64'd0);

    // Code entry: SW[0] covers increments at edges 8,16,24.
    wait_cyc(2);  sw = 4'b0001;
    wait_cyc(7);  check("a_entry_pre_tick", 64'(entry_o), 64'h0000);
    wait_cyc(8);  check("a_entry_tick1", 64'(entry_o), 64'h1000);
    wait_cyc(26); sw = 4'b0000;
    wait_cyc(30); check("a_entry_3", 64'(entry_o), 64'h3000);
    wait_cyc(32); pb = 1'b1;
    wait_cyc(39); check("a_code_latency", 64'(code_o), 64'h0000);
    wait_cyc(40);
    check("a_code", 64'(code_o), 64'h3000);
    check("a_entry_clr", 64'(entry_o), 64'h0000);
    check("a_attempts", 64'(attempts_o), 64'd0);
    check("a_lock", 64'(lock), 64'd0);
    wait_cyc(42); pb = 1'b0;
    wait_cyc(54);
    check("a_one_press_att", 64'(attempts_o), 64'd0);
    check("a_one_press_gv", 64'(gv_count), 64'd0);
    // Bounce shorter than the debounce window.
    wait_cyc(56); pb = 1'b1;
    wait_cyc(59); pb = 1'b0;
    wait_cyc(75);
    check("a_bounce_att", 64'(attempts_o), 64'd0);
    check("a_bounce_gv", 64'(gv_count), 64'd0);
    check("a_bounce_code", 64'(code_o), 64'h3000);

    // Correct guess: enter 1234 as code then as guess.
    do_reset();
    positions = 8'd4;
    wait_cyc(2);  sw = 4'b1111;
    wait_cyc(10); sw = 4'b1110;
    wait_cyc(18); sw = 4'b1100;
    wait_cyc(26); sw = 4'b1000;
    wait_cyc(34); sw = 4'b0000;
    wait_cyc(36); check("b_entry_code", 64'(entry_o), 64'h1234);
    wait_cyc(40); pb = 1'b1;
    wait_cyc(48); check("b_code", 64'(code_o), 64'h1234);
    wait_cyc(50); pb = 1'b0;
    wait_cyc(66); sw = 4'b1111;
    wait_cyc(74); sw = 4'b1110;
    wait_cyc(82); sw = 4'b1100;
    wait_cyc(90); sw = 4'b1000;
    wait_cyc(98); sw = 4'b0000;
    wait_cyc(100); check("b_entry_guess", 64'(entry_o), 64'h1234);
    gv_snap = gv_count;
    wait_cyc(104); pb = 1'b1;
    wait_cyc(111); check("b_gv_before", 64'(guess_valid_o), 64'd0);
    wait_cyc(112);
    check("b_guess", 64'(guess_o), 64'h1234);
    check("b_gv_pulse", 64'(guess_valid_o), 64'd1);
    check("b_attempts", 64'(attempts_o), 64'd1);
    check("b_lock_score", 64'(lock), 64'd0);
    wait_cyc(113);
    check("b_win", 64'({win_o, lock}), 64'b11);
    check("b_gv_end", 64'(guess_valid_o), 64'd0);
    wait_cyc(114); pb = 1'b0;
    wait_cyc(120); check("b_gv_count", 64'(gv_count - gv_snap), 64'd1);
    wait_cyc(128); pb = 1'b1;
    wait_cyc(136); check("b_restart", all_outs(), 64'd0);
    wait_cyc(138); pb = 1'b0;

    // Attempts: three wrong guesses then one more press.
    do_reset();
    positions = 8'd1;
    wait_cyc(8);  pb = 1'b1;
    wait_cyc(18); pb = 1'b0;
    for (int g = 1; g <= 3; g++) begin
      wait_cyc(8 + 24 * g); pb = 1'b1;
      wait_cyc(16 + 24 * g); check("c_attempts", 64'(attempts_o), 64'(g));
      wait_cyc(17 + 24 * g);
`ifdef MASTERMIND_ATTEMPT_LIMIT_EN
      check("c_lock", 64'({win_o, lock}), (g == 3) ? 64'b01 : 64'b00);
`else
      check("c_lock", 64'({win_o, lock}), 64'b00);
`endif
      wait_cyc(18 + 24 * g); pb = 1'b0;
    end
    wait_cyc(104); pb = 1'b1;
    wait_cyc(112);
`ifdef MASTERMIND_ATTEMPT_LIMIT_EN
    check("c_after_lose", all_outs(), 64'd0);
`else
    check("c_attempts4", 64'(attempts_o), 64'd4);
    check("c_gv4", 64'(guess_valid_o), 64'd1);
`endif
    wait_cyc(114); pb = 1'b0;

    // Digit wrap on the low digit, then a press coincident with a tick.
    do_reset();
    wait_cyc(2);   sw = 4'b1000;
    wait_cyc(120); check("d_entry_F", 64'(entry_o), 64'h000F);
    wait_cyc(128); check("d_entry_wrap", 64'(entry_o), 64'h0000);
    wait_cyc(138); sw = 4'b0000;
    wait_cyc(140); check("d_entry_17", 64'(entry_o), 64'h0001);
    wait_cyc(142); sw = 4'b1000;
    wait_cyc(152); check("d_entry_2", 64'(entry_o), 64'h0002);
    pb = 1'b1;
    wait_cyc(159); check("d_pre_press", 64'(code_o), 64'h0000);
    wait_cyc(160);
    check("d_code_pretick", 64'(code_o), 64'h0002);
    check("d_entry_clr", 64'(entry_o), 64'h0000);
    wait_cyc(162); pb = 1'b0;
    wait_cyc(167); check("d_entry_hold0", 64'(entry_o), 64'h0000);
    wait_cyc(168); check("d_entry_next", 64'(entry_o), 64'h0001);
    sw = 4'b0000;

    // Reset asserted while in SCORE.
    do_reset();
    wait_cyc(8);  pb = 1'b1;
    wait_cyc(18); pb = 1'b0;
    wait_cyc(32); pb = 1'b1;
    wait_cyc(40);
    check("e_in_score", 64'({attempts_o, guess_valid_o}), {55'd0, 8'd1, 1'b1});
    #1 rst = 1'b1; pb = 1'b0;
    #1 check("e_async_clear", all_outs(), 64'd0);
    repeat (3) @(negedge clk);
    gv_snap = gv_count;
    rst = 1'b0;
    wait_cyc(20);
    check("e_no_gv", 64'(gv_count - gv_snap), 64'd0);
    check("e_idle", all_outs(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
